// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback stage.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // Which result channel owns the write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_ALU
    } wb_src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy tracking plus sticky double-issue / stray-writeback error flag.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set_valid,
    input  logic [REG_ADDR_W-1:0] i_set_rd,
    input  logic                  i_clr_valid,
    input  logic [REG_ADDR_W-1:0] i_clr_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic                  o_sb_err
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                r_sb_err;
    logic                w_issue_err;
    logic                w_clr_err;

    // Register 0 never reports busy; addresses beyond NUM_REGS read as idle.
    function automatic logic busy_of(input logic [NUM_REGS-1:0] vec,
                                     input logic [REG_ADDR_W-1:0] rd);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (rd == REG_ADDR_W'(i)) hit = vec[i];
        end
        return hit;
    endfunction

    // Next busy vector: clear first so a same-cycle issue to that register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (i_clr_valid && (i_clr_rd == REG_ADDR_W'(i))) w_busy_nxt[i] = 1'b0;
            if (i_set_valid && (i_set_rd == REG_ADDR_W'(i))) w_busy_nxt[i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
        w_issue_err = i_set_valid && (i_set_rd != '0) && busy_of(r_busy, i_set_rd)
                      && !(i_clr_valid && (i_clr_rd == i_set_rd));
        w_clr_err   = i_clr_valid && (i_clr_rd != '0) && !busy_of(r_busy, i_clr_rd);
    end

    // Busy bits and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_sb_err <= r_sb_err | w_issue_err | w_clr_err;
        end
    end

    assign o_rs1_busy = busy_of(r_busy, i_rs1);
    assign o_rs2_busy = busy_of(r_busy, i_rs2);
    assign o_sb_err   = r_sb_err;

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter: loads beat ALU results onto a registered register-file write port.
// Optional macro WB_STATS_EN adds a 32-bit count of write cycles on wb_count.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  wren,
    output logic [REG_ADDR_W-1:0] wd_reg,
    output logic [XLEN-1:0]       rdv,
    output logic                  sb_err
`ifdef WB_STATS_EN
    ,
    output logic [31:0]           wb_count
`endif
);

    wb_src_t               w_src;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [XLEN-1:0]       w_data;
    logic                  w_write;
    logic                  r_wren;
    logic [REG_ADDR_W-1:0] r_wd_reg;
    logic [XLEN-1:0]       r_rdv;

    // Loads never stall, so the ALU channel is only ready when no load is offered.
    assign mem_ready = 1'b1;
    assign alu_ready = ~mem_valid;

    // Fixed-priority selection of the accepted transfer.
    always_comb begin
        w_src  = SRC_NONE;
        w_rd   = '0;
        w_data = '0;
        if (mem_valid) begin
            w_src  = SRC_MEM;
            w_rd   = mem_rd;
            w_data = mem_data;
        end else if (alu_valid) begin
            w_src  = SRC_ALU;
            w_rd   = alu_rd;
            w_data = alu_data;
        end
        w_write = (w_src != SRC_NONE) && (w_rd != '0);
    end

    // Write port register; address and data hold while idle, x0 writes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wren   <= 1'b0;
            r_wd_reg <= '0;
            r_rdv    <= '0;
        end else begin
            r_wren <= w_write;
            if (w_write) begin
                r_wd_reg <= w_rd;
                r_rdv    <= w_data;
            end
        end
    end

    assign wren   = r_wren;
    assign wd_reg = r_wd_reg;
    assign rdv    = r_rdv;

    wb_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_set_valid (issue_valid),
        .i_set_rd    (issue_rd),
        .i_clr_valid (w_write),
        .i_clr_rd    (w_rd),
        .i_rs1       (rs1),
        .i_rs2       (rs2),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy),
        .o_sb_err    (sb_err)
    );

`ifdef WB_STATS_EN
    logic [31:0] r_wb_count;

    // Counts cycles in which the write port is active; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) r_wb_count <= '0;
        else if (r_wren) r_wb_count <= r_wb_count + 32'd1;
    end

    assign wb_count = r_wb_count;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized traffic vs a model.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2, wd_reg;
    logic [31:0] alu_data, mem_data, rdv;
    logic        issue_valid, rs1_busy, rs2_busy, wren, sb_err;
`ifdef WB_STATS_EN
    logic [31:0] wb_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_busy [32];
    logic        m_wren;
    logic [4:0]  m_wd;
    logic [31:0] m_rdv;
    logic        m_err;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    regfile_writeback #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wren(wren), .wd_reg(wd_reg), .rdv(rdv), .sb_err(sb_err)
`ifdef WB_STATS_EN
        , .wb_count(wb_count)
`endif
    );

    // Behavioural model: which result wins, what lands on the port, which registers are pending.
    always @(posedge clk) begin : model
        bit          acc;
        logic [4:0]  rd;
        logic [31:0] d;
        if (rst) begin
            m_wren = 1'b0; m_wd = '0; m_rdv = '0; m_err = 1'b0; m_cnt = '0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            m_cnt = m_cnt + (m_wren ? 32'd1 : 32'd0);
            acc = mem_valid || alu_valid;
            rd  = mem_valid ? mem_rd : alu_rd;
            d   = mem_valid ? mem_data : alu_data;
            if (issue_valid && issue_rd != 0 && m_busy[issue_rd] && !(acc && rd == issue_rd))
                m_err = 1'b1;
            if (acc && rd != 0 && !m_busy[rd]) m_err = 1'b1;
            m_wren = acc && (rd != 0);
            if (m_wren) begin
                m_wd  = rd;
                m_rdv = d;
                m_busy[rd] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    end

    task automatic idle();
        rst = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; cyc(); idle();
    endtask

    task automatic issue(input logic [4:0] r);
        idle(); issue_valid = 1'b1; issue_rd = r; cyc(); idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'hDEAD;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: mem_ready=%b alu_ready=%b exp 1 0", mem_ready, alu_ready);
        end
        cyc(); cyc(); idle(); rs1 = 5'd9; #1;
        n_cmp++;
        if (wren !== 1'b0 || wd_reg !== 5'd0 || rdv !== 32'd0 || sb_err !== 1'b0 || rs1_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: wren=%b wd=%0d rdv=%h err=%b busy=%b exp 0 0 0 0 0",
                     wren, wd_reg, rdv, sb_err, rs1_busy);
        end
    endtask

    task automatic test_alu_write();
        issue(5'd5);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234; #1;
        n_cmp++;
        if (alu_ready !== 1'b1) begin
            n_bad++; $display("FAIL alu_ready: got %b exp 1", alu_ready);
        end
        cyc(); idle(); #1;
        n_cmp++;
        if (wren !== 1'b1 || wd_reg !== 5'd5 || rdv !== 32'h1234) begin
            n_bad++; $display("FAIL alu_write: wren=%b wd=%0d rdv=%h exp 1 5 1234", wren, wd_reg, rdv);
        end
        cyc(); #1;
        n_cmp++;
        if (wren !== 1'b0 || wd_reg !== 5'd5 || rdv !== 32'h1234 || sb_err !== 1'b0) begin
            n_bad++; $display("FAIL idle_hold: wren=%b wd=%0d rdv=%h err=%b exp 0 5 1234 0",
                              wren, wd_reg, rdv, sb_err);
        end
    endtask

    task automatic test_mem_priority();
        issue(5'd3); issue(5'd4);
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBB; #1;
        n_cmp++;
        if (alu_ready !== 1'b0) begin
            n_bad++; $display("FAIL alu_stall: alu_ready=%b exp 0", alu_ready);
        end
        cyc(); mem_valid = 1'b0; #1;
        n_cmp++;
        if (wren !== 1'b1 || wd_reg !== 5'd3 || rdv !== 32'hAA || alu_ready !== 1'b1) begin
            n_bad++; $display("FAIL mem_first: wren=%b wd=%0d rdv=%h rdy=%b exp 1 3 aa 1",
                              wren, wd_reg, rdv, alu_ready);
        end
        cyc(); idle(); #1;
        n_cmp++;
        if (wren !== 1'b1 || wd_reg !== 5'd4 || rdv !== 32'hBB || sb_err !== 1'b0) begin
            n_bad++; $display("FAIL alu_second: wren=%b wd=%0d rdv=%h err=%b exp 1 4 bb 0",
                              wren, wd_reg, rdv, sb_err);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        issue(5'd7); rs1 = 5'd7; #1;
        n_cmp++;
        if (rs1_busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_set: rs1_busy=%b exp 1", rs1_busy);
        end
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77; #1;
        n_cmp++;
        if (rs1_busy !== 1'b1) begin
            n_bad++; $display("FAIL no_bypass: rs1_busy=%b exp 1", rs1_busy);
        end
        cyc(); idle(); #1;
        n_cmp++;
        if (wren !== 1'b1 || rs1_busy !== 1'b0) begin
            n_bad++; $display("FAIL busy_clear: wren=%b rs1_busy=%b exp 1 0", wren, rs1_busy);
        end
    endtask

    task automatic test_set_clear();
        issue(5'd7);
        issue_valid = 1'b1; issue_rd = 5'd7;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h70;
        cyc(); idle(); rs1 = 5'd7; #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || sb_err !== 1'b0) begin
            n_bad++; $display("FAIL set_wins: busy=%b err=%b exp 1 0", rs1_busy, sb_err);
        end
        issue(5'd7); #1;
        n_cmp++;
        if (sb_err !== 1'b1) begin
            n_bad++; $display("FAIL double_issue: sb_err=%b exp 1", sb_err);
        end
        cyc(); #1;
        n_cmp++;
        if (sb_err !== 1'b1) begin
            n_bad++; $display("FAIL err_sticky: sb_err=%b exp 1", sb_err);
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF;
        cyc(); idle(); #1;
        n_cmp++;
        if (wren !== 1'b0 || sb_err !== 1'b0 || rdv !== 32'd0) begin
            n_bad++; $display("FAIL rd0_write: wren=%b err=%b rdv=%h exp 0 0 0", wren, sb_err, rdv);
        end
        issue(5'd0); rs1 = 5'd0; rs2 = 5'd0; #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || sb_err !== 1'b0) begin
            n_bad++; $display("FAIL rd0_issue: b1=%b b2=%b err=%b exp 0 0 0", rs1_busy, rs2_busy, sb_err);
        end
    endtask

    task automatic test_reset_mid();
        issue(5'd9); rs1 = 5'd9; #1;
        n_cmp++;
        if (rs1_busy !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_busy: busy=%b exp 1", rs1_busy);
        end
        rst = 1'b1; mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
        cyc(); idle(); #1;
        n_cmp++;
        if (wren !== 1'b0 || rs1_busy !== 1'b0 || sb_err !== 1'b0 || rdv !== 32'd0) begin
            n_bad++; $display("FAIL reset_mid: wren=%b busy=%b err=%b rdv=%h exp 0 0 0 0",
                              wren, rs1_busy, sb_err, rdv);
        end
    endtask

`ifdef WB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(k); alu_data = 32'(k); cyc();
        end
        idle(); cyc(); #1;
        n_cmp++;
        if (wb_count !== 32'd3) begin
            n_bad++; $display("FAIL wb_count: got %0d exp 3", wb_count);
        end
        do_reset(); #1;
        n_cmp++;
        if (wb_count !== 32'd0) begin
            n_bad++; $display("FAIL wb_count_rst: got %0d exp 0", wb_count);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst         = ($urandom_range(0, 24) == 0);
            mem_valid   = ($urandom_range(0, 2) == 0);
            mem_rd      = 5'($urandom_range(0, 31));
            mem_data    = $urandom;
            alu_valid   = ($urandom_range(0, 1) == 0);
            alu_rd      = 5'($urandom_range(0, 31));
            alu_data    = $urandom;
            issue_valid = ($urandom_range(0, 1) == 0);
            issue_rd    = 5'($urandom_range(0, 31));
            rs1         = 5'($urandom_range(0, 31));
            rs2         = 5'($urandom_range(0, 31));
            #1;
            n_cmp++;
            if (wren !== m_wren || wd_reg !== m_wd || rdv !== m_rdv || sb_err !== m_err) begin
                n_bad++;
                $display("FAIL rand_port[%0d]: wren=%b wd=%0d rdv=%h err=%b exp %b %0d %h %b",
                         k, wren, wd_reg, rdv, sb_err, m_wren, m_wd, m_rdv, m_err);
            end
            n_cmp++;
            if (rs1_busy !== m_busy[rs1] || rs2_busy !== m_busy[rs2] ||
                alu_ready !== !mem_valid || mem_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_comb[%0d]: b1=%b b2=%b ardy=%b mrdy=%b exp %b %b %b 1",
                         k, rs1_busy, rs2_busy, alu_ready, mem_ready,
                         m_busy[rs1], m_busy[rs2], !mem_valid);
            end
`ifdef WB_STATS_EN
            n_cmp++;
            if (wb_count !== m_cnt) begin
                n_bad++; $display("FAIL rand_count[%0d]: got %0d exp %0d", k, wb_count, m_cnt);
            end
`endif
            cyc();
        end
        idle();
    endtask

    initial begin
        idle(); rst = 1'b1; rs1 = '0; rs2 = '0;
        m_wren = 1'b0; m_wd = '0; m_rdv = '0; m_err = 1'b0; m_cnt = '0;
        @(negedge clk);
        test_reset();
        test_alu_write();
        test_mem_priority();
        test_hazard();
        test_set_clear();
        test_rd_zero();
        test_reset_mid();
`ifdef WB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of written values.
REQ-002 SHALL have parameter NUM_REGS, default 32, architectural register count (x0 hardwired zero).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports alu_valid in 1, alu_ready out 1, alu_rd in 5, alu_data in XLEN  ALU result channel.
REQ-006 SHALL have ports mem_valid in 1, mem_ready out 1, mem_rd in 5, mem_data in XLEN  load result channel.
REQ-007 SHALL have ports issue_valid in 1, issue_rd in 5  destination of newly issued instruction.
REQ-008 SHALL have ports rs1 in 5, rs2 in 5, rs1_busy out 1, rs2_busy out 1  hazard query.
REQ-009 SHALL have ports wren out 1, wd_reg out 5, rdv out XLEN  register file write port.
REQ-010 SHALL have port sb_err  output  1  sticky scoreboard error.

Function
REQ-011 Transfer on a channel SHALL occur in a cycle where valid and ready are both 1.
REQ-012 mem_ready SHALL be constant 1 (loads never stall); alu_ready SHALL equal NOT mem_valid (combinational).
REQ-013 Winning transfer SHALL appear on wren/wd_reg/rdv exactly one cycle after acceptance; no transfer -> wren=0 next cycle.
REQ-014 Transfer with rd=0 SHALL be accepted and discarded: wren=0, busy state unchanged.
REQ-015 wd_reg/rdv SHALL hold previous values when wren=0.
REQ-016 Scoreboard: one busy bit per register; busy[0] SHALL always read 0.
REQ-017 issue_valid with issue_rd!=0 SHALL set busy[issue_rd] at the clock edge.
REQ-018 Accepted transfer with rd!=0 SHALL clear busy[rd] at the same edge that registers wren=1.
REQ-019 Set and clear of the same register in one cycle: set SHALL win (busy stays 1).
REQ-020 rs1_busy/rs2_busy SHALL be combinational reads of current busy bits (no same-cycle bypass).
REQ-021 issue_valid to a register already busy and not cleared that cycle SHALL set sb_err=1; sb_err holds until reset.
REQ-022 Accepted transfer to a non-busy rd!=0 SHALL still write (wren=1) and SHALL set sb_err=1.

Reset
REQ-023 rst=1 at an edge SHALL force wren=0, wd_reg=0, rdv=0, all busy=0, sb_err=0.
REQ-024 Transfers accepted or issues presented in a reset cycle SHALL be discarded; ready outputs keep REQ-012 values during reset.

Configuration
REQ-025 Macro WB_STATS_EN defined: SHALL add output wb_count 32 bits, reset 0, +1 each cycle wren=1, wrapping 0xFFFFFFFF->0.
REQ-026 WB_STATS_EN undefined: wb_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package wb_pkg SHALL hold REG_ADDR_W=5, NUM_REGS default, and enum wb_src_t {SRC_NONE, SRC_MEM, SRC_ALU}.
REQ-028 Busy bits, set/clear and sb_err logic SHALL be sub-module wb_scoreboard; arbitration and output register stay top level.

Verification
REQ-029 alu_valid=1, alu_rd=5, alu_data=0x1234, mem_valid=0 -> alu_ready=1; next cycle wren=1, wd_reg=5, rdv=0x1234.
REQ-030 mem_valid=1 rd=3 data=0xAA and alu_valid=1 rd=4 same cycle -> alu_ready=0; next cycle wd_reg=3, rdv=0xAA; ALU written following cycle.
REQ-031 issue rd=7 -> rs1=7 gives rs1_busy=1; mem transfer rd=7 -> rs1_busy=0 from the cycle wren=1 onward.
REQ-032 issue rd=7 while transfer to rd=7 accepted same cycle -> busy[7] stays 1, sb_err=0; second issue rd=7 next cycle -> sb_err=1.
REQ-033 transfer rd=0 data=0xFFFF -> wren=0 next cycle, sb_err=0; issue rd=0 -> rs1=0 gives rs1_busy=0.
REQ-034 rst during accepted transfer with busy[9]=1 -> next cycle wren=0, rs1=9 busy=0; WB_STATS_EN: 3 writes gives wb_count=3, rst gives 0.
